// File: rtl/uart_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_receiver
// Description : 8N1 UART receiver, LSB first, idle-high line. The serial input
//               is synchronised and then majority-voted over three samples.
//               The received byte is presented on a valid/ready handshake.
//               Stop-bit errors and dropped bytes are reported as
//               single-cycle pulses.
// Ports       : clk_i        - single clock, rising edge
//               rst_i        - synchronous active-high reset
//               uart_rx_i    - asynchronous serial line
//               rx_data_o    - received byte (stable while rx_valid_o=1)
//               rx_valid_o   - unconsumed byte present
//               rx_ready_i   - consumer accept
//               frame_err_o  - one-cycle pulse, stop bit sampled low
//               overrun_o    - one-cycle pulse, completed byte dropped
//               busy_o       - receiver FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_TICK = c_CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [c_CNT_W-1:0] c_LAST_TICK = c_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Synchroniser and sample history. The second synchroniser flop is the
    // newest history entry (h0); h1 and h2 hold the two older samples.
    logic r_sync1;
    logic r_h0;
    logic r_h1;
    logic r_h2;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_idx;
    logic [7:0]           r_shift;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]           w_idx_nxt;
    logic [7:0]           w_shift_nxt;
    logic [7:0]           w_data_nxt;
    logic                 w_valid_nxt;
    logic                 w_frame_err_nxt;
    logic                 w_overrun_nxt;
    logic                 w_maj;
    logic                 w_fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_h0    <= 1'b1;
            r_h1    <= 1'b1;
            r_h2    <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_i;
            r_h0    <= r_sync1;
            r_h1    <= r_h0;
            r_h2    <= r_h1;
        end
    end

    assign w_maj  = (r_h0 & r_h1) | (r_h0 & r_h2) | (r_h1 & r_h2);
    // Edge rule: the line must have been high before it is seen low, so a
    // held-low line (break or post-error) never re-triggers a frame.
    assign w_fall = r_h1 & ~r_h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        // A completed handshake frees the output register next cycle.
        w_valid_nxt     = r_valid & ~rx_ready_i;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (r_cnt == c_HALF_TICK) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    w_state_nxt = w_maj ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (r_cnt == c_LAST_TICK) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_maj;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (r_cnt == c_LAST_TICK) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (!w_maj) begin
                        w_frame_err_nxt = 1'b1;
                    end else if (!r_valid || rx_ready_i) begin
                        // Covers the accept-and-load case: the old byte is
                        // taken this cycle and the new one replaces it.
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_overrun_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rx_data_o   = r_data;
    assign rx_valid_o  = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
    assign busy_o      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
